// File: rtl/rr_mult_pkg.sv
// Shared types, width helpers and parameter legality check for the
// recursive-split pipelined multiplier.
package rr_mult_pkg;

  typedef enum logic {
    RR_EXACT  = 1'b0,
    RR_APPROX = 1'b1
  } rr_mode_e;

  function automatic int hw(input int n, input int k);
    return n - k;
  endfunction

  function automatic int pw(input int n);
    return 2 * n;
  endfunction

  function automatic bit params_ok(input int n, input int k, input int t);
    return (n >= 2) && (n <= 32) && (k >= 1) && (k <= n - 1) &&
           (t >= 0) && (t <= 2 * k);
  endfunction

endpackage

// File: rtl/rr_mult_pipe_subproduct.sv
// Exact unsigned WA x WB multiplier, purely combinational.
module rr_subproduct #(
  parameter int WA = 2,
  parameter int WB = 2
) (
  input  logic [WA-1:0]    i_a,
  input  logic [WB-1:0]    i_b,
  output logic [WA+WB-1:0] o_p
);

  assign o_p = (WA+WB)'(i_a) * (WA+WB)'(i_b);

endmodule

// File: rtl/rr_mult_pipe.sv
// Three-stage split multiplier: S1 operands, S2 four sub-products (with
// optional low-bit truncation of AL*BL), S3 recombined 2N-bit product.
module rr_mult_pipe
  import rr_mult_pkg::*;
#(
  parameter int N = 4,
  parameter int K = 3,
  parameter int T = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [pw(N)-1:0] out_p
);

  if (!params_ok(N, K, T)) begin : g_param_check
    $fatal(1, "rr_mult_pipe: illegal parameters N=%0d K=%0d T=%0d", N, K, T);
  end

  localparam int H  = hw(N, K);
  localparam int PW = pw(N);
  localparam int LW = 2 * K;
  localparam logic [LW-1:0] TMASK = {LW{1'b1}} << T;

  logic            r_v1, r_v2, r_v3;
  logic [N-1:0]    r_a, r_b;
  rr_mode_e        r_mode;
  logic [2*H-1:0]  r_phh;
  logic [N-1:0]    r_phl, r_plh;
  logic [LW-1:0]   r_pll;
  logic [PW-1:0]   r_p;

  logic            w_advance;
  logic [2*H-1:0]  w_phh;
  logic [N-1:0]    w_phl, w_plh;
  logic [LW-1:0]   w_pll, w_pll_t;
  logic [PW-1:0]   w_sum;

  // Handshake: a beat moves on in_valid & in_ready and leaves on
  // out_valid & out_ready. The whole pipe advances together whenever the
  // output slot is empty or being drained, so in_ready never sees in_valid.
  assign w_advance = !r_v3 || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v3;
  assign out_p     = r_p;

  rr_subproduct #(.WA(H), .WB(H)) u_hh (.i_a(r_a[N-1:K]), .i_b(r_b[N-1:K]), .o_p(w_phh));
  rr_subproduct #(.WA(H), .WB(K)) u_hl (.i_a(r_a[N-1:K]), .i_b(r_b[K-1:0]), .o_p(w_phl));
  rr_subproduct #(.WA(K), .WB(H)) u_lh (.i_a(r_a[K-1:0]), .i_b(r_b[N-1:K]), .o_p(w_plh));
  rr_subproduct #(.WA(K), .WB(K)) u_ll (.i_a(r_a[K-1:0]), .i_b(r_b[K-1:0]), .o_p(w_pll));

  assign w_pll_t = (r_mode == RR_APPROX) ? (w_pll & TMASK) : w_pll;

  // Middle term needs N+1+K bits at most, which fits in 2N since K <= N-1.
  assign w_sum = (PW'(r_phh) << LW) + ((PW'(r_phl) + PW'(r_plh)) << K) + PW'(r_pll);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= RR_EXACT;
      r_phh  <= '0;
      r_phl  <= '0;
      r_plh  <= '0;
      r_pll  <= '0;
      r_p    <= '0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_mode <= in_approx ? RR_APPROX : RR_EXACT;
      end
      if (r_v1) begin
        r_phh <= w_phh;
        r_phl <= w_phl;
        r_plh <= w_plh;
        r_pll <= w_pll_t;
      end
      if (r_v2) begin
        r_p <= w_sum;
      end
    end
  end

endmodule
